bus_master_agent: RTL and testbench
===================================

Name: bus_master_agent

Overview:
Requester-side agent for the round-robin bus arbiter. It sits between a local master core and one req/grant pair of the arbiter. Write-burst commands from the core are queued in a small FIFO. For each queued command the agent requests the bus, waits for grant, and drives the burst beat by beat. It survives grant loss mid-burst and releases req between bursts so the arbiter can rotate.

Parameters:
ADDR_WIDTH, 16, width of burst start address and bus_addr
DATA_WIDTH, 32, width of write data
FIFO_DEPTH, 4, command queue entries (power of two, >=2)
GRANT_TIMEOUT, 15, cycles in REQ without grant before timeout_err

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  core presents a burst command
cmd_ready  out  1  queue not full; command accepted on cmd_valid&&cmd_ready
cmd_addr  in  ADDR_WIDTH  burst start address
cmd_len  in  3  beats minus one (0..7 = 1..8 beats)
wdata_valid  in  1  core has next beat data
wdata  in  DATA_WIDTH  beat data
wdata_ready  out  1  beat consumed this cycle (= bus_valid&&bus_ack)
req  out  1  request to arbiter (registered)
grant  in  1  this agent's grant bit from the arbiter
bus_valid  out  1  beat on bus
bus_addr  out  ADDR_WIDTH  beat address
bus_data  out  DATA_WIDTH  beat data (= wdata)
bus_last  out  1  final beat of burst
bus_ack  in  1  target accepts beat
busy  out  1  FIFO non-empty or state != IDLE
burst_done  out  1  one-cycle pulse after final beat accepted
timeout_err  out  1  one-cycle pulse on grant timeout

Behaviour:
- Reset (reset_n=0 at edge): FIFO empty, state IDLE. req, burst_done, timeout_err, beat counter, timeout counter all 0. Combinational outputs follow from this: bus_valid=0, bus_last=0, wdata_ready=0, cmd_ready=1. Reset mid-burst aborts the burst and flushes all queued commands.
- FIFO: accepted commands are written at the edge. cmd_ready = !full. Simultaneous push and pop while full is not allowed: cmd_ready is already 0.
- FSM states: IDLE, REQ, BURST, RELEASE.
- IDLE: if FIFO non-empty, go to REQ and set req=1 at the same edge. A command accepted at edge E0 into an empty, idle agent gives req=1 from E1.
- REQ: req=1. On grant=1 go to BURST; beat counter=0, timeout counter=0. Otherwise increment the timeout counter. When the count reaches GRANT_TIMEOUT, pulse timeout_err, go to RELEASE (req=0 for exactly one cycle), then re-request the same command. The command is never dropped.
- BURST: req held at 1.
  - bus_valid = grant && wdata_valid.
  - bus_addr = head.addr + beat counter, modulo 2^ADDR_WIDTH (wrap allowed).
  - bus_last = bus_valid && (beat counter == head.len).
  - A beat completes on bus_valid && bus_ack; the beat counter then increments.
- Grant loss in BURST: grant=0 forces bus_valid=0. The agent stays in BURST and keeps req high. It resumes at the same beat when grant returns, with no restart and no timeout counting.
- Final beat accepted: pop FIFO, pulse burst_done the next cycle, go to RELEASE.
- RELEASE: req=0 for one cycle, then IDLE. Back-to-back bursts therefore show a req gap of >=1 cycle.
- wdata_valid=0 during BURST stalls the burst; req stays held.
- Address and data come from the FIFO head and wdata only. Commands accepted during a burst do not affect it.

Test Plan:
- Single burst, cmd_addr=0x0100, len=3; grant rises 2 cycles after req; bus_ack tied 1 -> four beats at addr 0x0100..0x0103; bus_last on 0x0103; burst_done pulse; req low 1 cycle after the last beat.
- Push 5 commands with no grant -> 4 accepted, cmd_ready=0 on the 5th. Then grant=1 -> 4 bursts in order, each separated by a req-low cycle, and busy falls after the last.
- grant held 0 -> timeout_err pulses when the REQ count reaches 15. req is 0 for one cycle, then 1 again. Grant later -> original command executes.
- len=7, grant drops after beat 2 for 3 cycles -> bus_valid=0 during the gap, req stays 1; resume at start+3; 8 beats total, no duplicated addresses.
- cmd_addr=0xFFFE, len=3 -> bus_addr 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- reset_n=0 for one cycle at beat 1 with 2 more commands queued -> next cycle req=0, bus_valid=0, busy=0, cmd_ready=1.

Source files
------------

// File: rtl/bus_master_agent.sv
// Requester-side agent for a round-robin bus arbiter: queues write-burst commands
// and drives each burst beat by beat once the arbiter grants the bus.
module bus_master_agent #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int GRANT_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_len,
  input  logic                  wdata_valid,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_ready,
  output logic                  req,
  input  logic                  grant,
  output logic                  bus_valid,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_last,
  input  logic                  bus_ack,
  output logic                  busy,
  output logic                  burst_done,
  output logic                  timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(GRANT_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, REQ, BURST, RELEASE} state_t;

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [2:0]            fifo_len  [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic                  empty, full, push, pop;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [2:0]            head_len;

  state_t          state, state_next;
  logic [2:0]      beat_cnt, beat_next;
  logic [TO_W-1:0] to_cnt, to_next;
  logic            req_next, done_next, terr_next, beat_fire;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign head_addr = fifo_addr[rd_ptr[PTR_W-1:0]];
  assign head_len  = fifo_len[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[PTR_W-1:0]] <= cmd_addr;
      fifo_len[wr_ptr[PTR_W-1:0]]  <= cmd_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign bus_valid   = (state == BURST) && grant && wdata_valid;
  assign bus_addr    = head_addr + ADDR_WIDTH'(beat_cnt);
  assign bus_data    = wdata;
  assign bus_last    = bus_valid && (beat_cnt == head_len);
  assign beat_fire   = bus_valid && bus_ack;
  assign wdata_ready = beat_fire;
  assign busy        = !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      req         <= 1'b0;
      beat_cnt    <= '0;
      to_cnt      <= '0;
      burst_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      req         <= req_next;
      beat_cnt    <= beat_next;
      to_cnt      <= to_next;
      burst_done  <= done_next;
      timeout_err <= terr_next;
    end
  end

  // RELEASE re-requests directly when work is pending so the req gap is one cycle.
  always_comb begin
    state_next = state;
    req_next   = req;
    beat_next  = beat_cnt;
    to_next    = to_cnt;
    done_next  = 1'b0;
    terr_next  = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = REQ;
          req_next   = 1'b1;
          to_next    = '0;
        end
      end
      REQ: begin
        if (grant) begin
          state_next = BURST;
          beat_next  = '0;
          to_next    = '0;
        end else if (to_cnt == TO_LAST) begin
          state_next = RELEASE;
          req_next   = 1'b0;
          terr_next  = 1'b1;
          to_next    = '0;
        end else begin
          to_next = to_cnt + TO_ONE;
        end
      end
      BURST: begin
        if (beat_fire) begin
          if (beat_cnt == head_len) begin
            pop        = 1'b1;
            done_next  = 1'b1;
            state_next = RELEASE;
            req_next   = 1'b0;
            beat_next  = '0;
          end else begin
            beat_next = beat_cnt + 3'd1;
          end
        end
      end
      RELEASE: begin
        if (!empty) begin
          state_next = REQ;
          req_next   = 1'b1;
          to_next    = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_master_agent.sv
// Directed bench for bus_master_agent: single burst, queue full, grant timeout,
// grant loss mid-burst, address wrap and reset mid-burst.
module tb_bus_master_agent;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [2:0]  cmd_len;
  logic        wdata_valid;
  logic [31:0] wdata;
  logic        wdata_ready;
  logic        req;
  logic        grant;
  logic        bus_valid;
  logic [15:0] bus_addr;
  logic [31:0] bus_data;
  logic        bus_last;
  logic        bus_ack;
  logic        busy;
  logic        burst_done;
  logic        timeout_err;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  bus_master_agent #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .FIFO_DEPTH(4), .GRANT_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .req(req), .grant(grant),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_data(bus_data), .bus_last(bus_last),
    .bus_ack(bus_ack), .busy(busy), .burst_done(burst_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck run still terminates with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic g, input logic wv, input logic ack);
    grant       = g;
    wdata_valid = wv;
    bus_ack     = ack;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_cnt = check_cnt + 1;
    assert (observed === expected) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {31'd0, observed}, {31'd0, expected});
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (bus_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkBit(tag, bus_valid, 1'b1);
  endtask

  logic [15:0] wrap_exp [4];

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wdata     = '0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #1;
    checkBit("rst_req", req, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_cmd_ready", cmd_ready, 1'b1);
    checkBit("rst_bus_valid", bus_valid, 1'b0);
    checkBit("rst_burst_done", burst_done, 1'b0);
    checkBit("rst_timeout_err", timeout_err, 1'b0);
    reset_n = 1'b1;

    // Single burst 0x0100 len 3, grant two cycles after req.
    $display("[TB] single burst");
    tick();
    cmd_valid = 1'b1; cmd_addr = 16'h0100; cmd_len = 3'd3;
    #1 checkBit("t1_cmd_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    #1 checkBit("t1_req_e0", req, 1'b0);
    checkBit("t1_busy_e0", busy, 1'b1);
    tick();
    checkBit("t1_req_e1", req, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1);
    #1 checkBit("t1_valid_in_req", bus_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      wdata = 32'hA000_0000 + i;
      #1;
      checkBit("t1_valid", bus_valid, 1'b1);
      checkOutput("t1_addr", {16'd0, bus_addr}, 32'h0100 + i);
      checkOutput("t1_data", bus_data, 32'hA000_0000 + i);
      checkBit("t1_last", bus_last, (i == 3));
      checkBit("t1_wdata_ready", wdata_ready, 1'b1);
    end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkBit("t1_done", burst_done, 1'b1);
    checkBit("t1_req_gap", req, 1'b0);
    checkBit("t1_valid_after", bus_valid, 1'b0);
    tick();
    checkBit("t1_done_pulse", burst_done, 1'b0);
    checkBit("t1_busy_end", busy, 1'b0);

    // Five pushes without grant: only four fit.
    $display("[TB] queue full");
    for (int k = 0; k < 5; k++) begin
      cmd_valid = 1'b1; cmd_addr = 16'h2000 + 16'(k * 16); cmd_len = 3'd1;
      #1 checkBit("t2_cmd_ready", cmd_ready, (k < 4));
      tick();
    end
    cmd_valid = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      waitValid("t2_wait_valid");
      checkOutput("t2_addr0", {16'd0, bus_addr}, 32'h2000 + k * 16);
      checkBit("t2_last0", bus_last, 1'b0);
      tick();
      checkOutput("t2_addr1", {16'd0, bus_addr}, 32'h2001 + k * 16);
      checkBit("t2_last1", bus_last, 1'b1);
      tick();
      checkBit("t2_done", burst_done, 1'b1);
      checkBit("t2_req_gap", req, 1'b0);
      checkBit("t2_valid_gap", bus_valid, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkBit("t2_busy_end", busy, 1'b0);

    // Grant never comes: timeout after 15 requesting cycles, then re-request.
    $display("[TB] grant timeout");
    cmd_valid = 1'b1; cmd_addr = 16'h3000; cmd_len = 3'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    checkBit("t3_req_e1", req, 1'b1);
    for (int c = 0; c < 14; c++) tick();
    checkBit("t3_req_e15", req, 1'b1);
    checkBit("t3_terr_e15", timeout_err, 1'b0);
    tick();
    checkBit("t3_req_e16", req, 1'b0);
    checkBit("t3_terr_e16", timeout_err, 1'b1);
    tick();
    checkBit("t3_req_e17", req, 1'b1);
    checkBit("t3_terr_e17", timeout_err, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    checkBit("t3_valid", bus_valid, 1'b1);
    checkOutput("t3_addr", {16'd0, bus_addr}, 32'h3000);
    checkBit("t3_last", bus_last, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkBit("t3_done", burst_done, 1'b1);
    tick();
    checkBit("t3_busy_end", busy, 1'b0);

    // Eight beats with a 3-cycle grant loss after beat 2 and a data stall at beat 5.
    $display("[TB] grant loss");
    applyStimulus(1'b1, 1'b1, 1'b1);
    cmd_valid = 1'b1; cmd_addr = 16'h4000; cmd_len = 3'd7;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4_addr_pre", {16'd0, bus_addr}, 32'h4000 + i);
      checkBit("t4_valid_pre", bus_valid, 1'b1);
      tick();
    end
    grant = 1'b0;
    for (int g = 0; g < 3; g++) begin
      #1 checkBit("t4_valid_gap", bus_valid, 1'b0);
      checkBit("t4_req_gap", req, 1'b1);
      tick();
    end
    grant = 1'b1;
    for (int i = 3; i < 8; i++) begin
      if (i == 5) begin
        wdata_valid = 1'b0;
        #1 checkBit("t4_valid_stall", bus_valid, 1'b0);
        checkBit("t4_req_stall", req, 1'b1);
        tick();
        wdata_valid = 1'b1;
      end
      #1 checkBit("t4_valid_post", bus_valid, 1'b1);
      checkOutput("t4_addr_post", {16'd0, bus_addr}, 32'h4000 + i);
      checkBit("t4_last", bus_last, (i == 7));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkBit("t4_done", burst_done, 1'b1);
    checkBit("t4_req_end", req, 1'b0);
    checkBit("t4_terr", timeout_err, 1'b0);
    tick();

    // Address wrap at the top of the address space.
    $display("[TB] address wrap");
    wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF;
    wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;
    applyStimulus(1'b1, 1'b1, 1'b1);
    cmd_valid = 1'b1; cmd_addr = 16'hFFFE; cmd_len = 3'd3;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      checkBit("t5_valid", bus_valid, 1'b1);
      checkOutput("t5_addr", {16'd0, bus_addr}, {16'd0, wrap_exp[i]});
      checkBit("t5_last", bus_last, (i == 3));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1 checkBit("t5_done", burst_done, 1'b1);
    tick();

    // Reset during beat 1 with two more commands queued.
    $display("[TB] reset mid-burst");
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'b1; cmd_addr = 16'h6000 + 16'(k * 256); cmd_len = 3'd3;
      tick();
    end
    cmd_valid = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("t6_addr0", {16'd0, bus_addr}, 32'h6000);
    tick();
    checkOutput("t6_addr1", {16'd0, bus_addr}, 32'h6001);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1 checkBit("t6_req", req, 1'b0);
    checkBit("t6_valid", bus_valid, 1'b0);
    checkBit("t6_busy", busy, 1'b0);
    checkBit("t6_cmd_ready", cmd_ready, 1'b1);
    tick();
    checkBit("t6_busy_flushed", busy, 1'b0);
    checkBit("t6_req_flushed", req, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
